// File: rtl/status_flag_reader_pkg.sv
// Shared definitions for the status flag reader: branch condition codes,
// the default shadow-stack depth and the condition evaluation function.
package status_flag_reader_pkg;

    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_C      = 3'b001,
        COND_NC     = 3'b010,
        COND_Z      = 3'b011,
        COND_NZ     = 3'b100,
        COND_A      = 3'b101,
        COND_BE     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    // COND_A is "above" (carry set, not zero); COND_BE is its complement.
    function automatic logic cond_eval(input logic [2:0] code,
                                       input logic       c,
                                       input logic       z);
        logic r;
        case (code)
            COND_ALWAYS: r = 1'b1;
            COND_C:      r = c;
            COND_NC:     r = ~c;
            COND_Z:      r = z;
            COND_NZ:     r = ~z;
            COND_A:      r = c & ~z;
            COND_BE:     r = ~c | z;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/status_flag_reader_flag_stack.sv
// LIFO of {carry, zero} pairs with registered full/empty and a sticky
// misuse flag. The top entry is presented combinationally on dout.
module flag_stack
    import status_flag_reader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic       pop_ok,
    output logic       full,
    output logic       empty,
    output logic       err
);

    localparam logic [PTR_W:0] ONE       = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] COUNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [1:0]     r_mem [DEPTH];
    logic [PTR_W:0] r_count;
    logic           r_full;
    logic           r_empty;
    logic           r_err;

    logic [PTR_W:0] w_count_next;
    logic [PTR_W:0] w_count_m1;
    logic           w_push_ok;
    logic           w_pop_ok;
    logic           w_misuse;

    always_comb begin
        w_push_ok    = push & ~pop & ~r_full;
        w_pop_ok     = pop & ~push & ~r_empty;
        // Simultaneous push/pop is refused outright rather than treated as a swap.
        w_misuse     = (push & pop) | (push & ~pop & r_full) | (pop & ~push & r_empty);
        w_count_m1   = r_count - ONE;
        w_count_next = r_count;
        if (w_push_ok) begin
            w_count_next = r_count + ONE;
        end else if (w_pop_ok) begin
            w_count_next = w_count_m1;
        end
    end

    always_ff @(posedge clock) begin
        if (!notReset) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == COUNT_MAX);
            r_empty <= (w_count_next == '0);
            r_err   <= r_err | w_misuse;
        end
    end

    // Storage is deliberately left unreset; only the count defines validity.
    always_ff @(posedge clock) begin
        if (notReset && w_push_ok) begin
            r_mem[r_count[PTR_W-1:0]] <= din;
        end
    end

    assign dout   = r_mem[w_count_m1[PTR_W-1:0]];
    assign pop_ok = w_pop_ok;
    assign full   = r_full;
    assign empty  = r_empty;
    assign err    = r_err;

endmodule

// File: rtl/status_flag_reader.sv
// Consumer end of the carry/zero status register: registered branch
// condition evaluation plus a flag shadow stack restored via notLoadOut.
module status_flag_reader
    import status_flag_reader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       cIn,
    input  logic       zIn,
    input  logic       condValid,
    input  logic [2:0] cond,
    output logic       resultValid,
    output logic       takeOut,
    input  logic       push,
    input  logic       pop,
    output logic       cOut,
    output logic       zOut,
    output logic       notLoadOut,
    output logic       full,
    output logic       empty,
    output logic       err
);

    logic       r_result_valid;
    logic       r_take;
    logic       r_c_out;
    logic       r_z_out;
    logic       r_not_load;

    logic [1:0] w_top;
    logic       w_pop_ok;

    flag_stack #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_stack (
        .clock    (clock),
        .notReset (notReset),
        .push     (push),
        .pop      (pop),
        .din      ({cIn, zIn}),
        .dout     (w_top),
        .pop_ok   (w_pop_ok),
        .full     (full),
        .empty    (empty),
        .err      (err)
    );

    always_ff @(posedge clock) begin
        if (!notReset) begin
            r_result_valid <= 1'b0;
            r_take         <= 1'b0;
            r_c_out        <= 1'b0;
            r_z_out        <= 1'b0;
            r_not_load     <= 1'b1;
        end else begin
            r_result_valid <= condValid;
            if (condValid) begin
                r_take <= cond_eval(cond, cIn, zIn);
            end
            // The status register loads on the edge after this pulse, so
            // evaluation in the pop cycle still sees the pre-restore flags.
            r_not_load <= ~w_pop_ok;
            if (w_pop_ok) begin
                r_c_out <= w_top[1];
                r_z_out <= w_top[0];
            end
        end
    end

    assign resultValid = r_result_valid;
    assign takeOut     = r_take;
    assign cOut        = r_c_out;
    assign zOut        = r_z_out;
    assign notLoadOut  = r_not_load;

endmodule

// File: tb/tb_status_flag_reader.sv
// Directed bench for status_flag_reader: condition codes, stack push/pop,
// misuse cases and reset interaction, with hand-computed expectations.
module tb_status_flag_reader;
    import status_flag_reader_pkg::*;

    logic       clock;
    logic       notReset;
    logic       cIn;
    logic       zIn;
    logic       condValid;
    logic [2:0] cond;
    logic       resultValid;
    logic       takeOut;
    logic       push;
    logic       pop;
    logic       cOut;
    logic       zOut;
    logic       notLoadOut;
    logic       full;
    logic       empty;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;

    status_flag_reader #(
        .DEPTH (4),
        .PTR_W (2)
    ) u_dut (
        .clock       (clock),
        .notReset    (notReset),
        .cIn         (cIn),
        .zIn         (zIn),
        .condValid   (condValid),
        .cond        (cond),
        .resultValid (resultValid),
        .takeOut     (takeOut),
        .push        (push),
        .pop         (pop),
        .cOut        (cOut),
        .zOut        (zOut),
        .notLoadOut  (notLoadOut),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic eval_step(input string tag, input logic [2:0] code, input logic exp);
        condValid = 1'b1;
        cond      = code;
        tick();
        check1({tag, "_valid"}, resultValid, 1'b1);
        check1({tag, "_take"}, takeOut, exp);
    endtask

    task automatic push_step(input logic c, input logic z);
        cIn  = c;
        zIn  = z;
        push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic pop_step(input string tag, input logic exp_c, input logic exp_z);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check1({tag, "_nload"}, notLoadOut, 1'b0);
        check1({tag, "_c"}, cOut, exp_c);
        check1({tag, "_z"}, zOut, exp_z);
        tick();
        check1({tag, "_nload_end"}, notLoadOut, 1'b1);
    endtask

    task automatic do_reset();
        notReset = 1'b0;
        tick();
        tick();
        notReset = 1'b1;
    endtask

    initial begin
        notReset  = 1'b0;
        cIn       = 1'b0;
        zIn       = 1'b0;
        condValid = 1'b1;
        cond      = COND_ALWAYS;
        push      = 1'b1;
        pop       = 1'b0;

        // Reset with push and condValid held
        tick();
        tick();
        check1("rst_empty", empty, 1'b1);
        check1("rst_full", full, 1'b0);
        check1("rst_nload", notLoadOut, 1'b1);
        check1("rst_rvalid", resultValid, 1'b0);
        check1("rst_take", takeOut, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_cout", cOut, 1'b0);
        check1("rst_zout", zOut, 1'b0);
        check3("rst_count", u_dut.u_stack.r_count, 3'd0);
        notReset  = 1'b1;
        push      = 1'b0;
        condValid = 1'b0;
        tick();

        // Condition codes, back-to-back, C=1 Z=0
        cIn = 1'b1;
        zIn = 1'b0;
        eval_step("c10_C", COND_C, 1'b1);
        eval_step("c10_Z", COND_Z, 1'b0);
        eval_step("c10_A", COND_A, 1'b1);
        eval_step("c10_BE", COND_BE, 1'b0);
        eval_step("c10_ALW", COND_ALWAYS, 1'b1);
        eval_step("c10_NEV", COND_NEVER, 1'b0);
        eval_step("c10_NZ", COND_NZ, 1'b1);
        condValid = 1'b0;
        tick();
        check1("idle_valid", resultValid, 1'b0);
        check1("idle_hold", takeOut, 1'b1);

        // C=0 Z=1
        cIn = 1'b0;
        zIn = 1'b1;
        eval_step("c01_NC", COND_NC, 1'b1);
        eval_step("c01_NZ", COND_NZ, 1'b0);
        eval_step("c01_A", COND_A, 1'b0);
        eval_step("c01_BE", COND_BE, 1'b1);
        eval_step("c01_C", COND_C, 1'b0);
        condValid = 1'b0;

        // Fill the stack
        push_step(1'b1, 1'b0);
        check1("push1_empty", empty, 1'b0);
        check1("push1_full", full, 1'b0);
        push_step(1'b0, 1'b1);
        push_step(1'b1, 1'b1);
        check1("push3_full", full, 1'b0);
        push_step(1'b0, 1'b0);
        check1("push4_full", full, 1'b1);
        check3("push4_count", u_dut.u_stack.r_count, 3'd4);

        // First pop alongside an evaluation that must see pre-restore flags
        cIn       = 1'b1;
        zIn       = 1'b0;
        condValid = 1'b1;
        cond      = COND_A;
        pop       = 1'b1;
        tick();
        pop       = 1'b0;
        condValid = 1'b0;
        check1("pop1_take", takeOut, 1'b1);
        check1("pop1_nload", notLoadOut, 1'b0);
        check1("pop1_c", cOut, 1'b0);
        check1("pop1_z", zOut, 1'b0);
        check1("pop1_full", full, 1'b0);
        tick();
        check1("pop1_nload_end", notLoadOut, 1'b1);
        check1("pop1_c_hold", cOut, 1'b0);
        pop_step("pop2", 1'b1, 1'b1);
        pop_step("pop3", 1'b0, 1'b1);
        pop_step("pop4", 1'b1, 1'b0);
        check1("drain_empty", empty, 1'b1);
        check1("drain_err", err, 1'b0);

        // Pop when empty
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check1("upop_nload", notLoadOut, 1'b1);
        check1("upop_err", err, 1'b1);
        check1("upop_c_hold", cOut, 1'b1);
        check1("upop_z_hold", zOut, 1'b0);
        check1("upop_empty", empty, 1'b1);

        // Push when full
        push_step(1'b0, 1'b0);
        push_step(1'b0, 1'b1);
        push_step(1'b1, 1'b0);
        push_step(1'b1, 1'b1);
        push_step(1'b0, 1'b0);
        check3("opush_count", u_dut.u_stack.r_count, 3'd4);
        check1("opush_full", full, 1'b1);
        check1("opush_err", err, 1'b1);
        tick();
        check1("err_sticky", err, 1'b1);
        do_reset();
        check1("err_clear", err, 1'b0);
        check1("rst2_empty", empty, 1'b1);

        // Simultaneous push and pop with two entries
        push_step(1'b1, 1'b1);
        push_step(1'b0, 1'b1);
        cIn  = 1'b0;
        zIn  = 1'b0;
        push = 1'b1;
        pop  = 1'b1;
        tick();
        push = 1'b0;
        pop  = 1'b0;
        check3("pp_count", u_dut.u_stack.r_count, 3'd2);
        check1("pp_nload", notLoadOut, 1'b1);
        check1("pp_err", err, 1'b1);
        pop_step("pp_pop1", 1'b0, 1'b1);

        // Reset during the load pulse
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check1("rpop_nload", notLoadOut, 1'b0);
        check1("rpop_c", cOut, 1'b1);
        check1("rpop_z", zOut, 1'b1);
        notReset = 1'b0;
        tick();
        notReset = 1'b1;
        check1("rpop_nload_rst", notLoadOut, 1'b1);
        check1("rpop_c_rst", cOut, 1'b0);
        check1("rpop_z_rst", zOut, 1'b0);
        check1("rpop_empty_rst", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
